if_stage: RTL
=============

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000 (sll $0,$0,0), IR value of an inserted bubble.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 IF_ID_stall  in  1  load-use stall from hazard unit; holds PC and IF/ID.
REQ-007 Branch_EX  in  1  taken branch resolved in EX.
REQ-008 Branch_target_EX  in  32  branch target address.
REQ-009 Jump_ID  in  1  j/jal/jr decoded in ID.
REQ-010 Jump_target_ID  in  32  jump target address.
REQ-011 Instr_valid  in  1  instruction memory returns valid data this cycle.
REQ-012 Instr_data  in  32  instruction word at Instr_addr, combinational from memory.
REQ-013 Instr_addr  out  32  current PC to instruction memory.
REQ-014 IR_IF_ID_out  out  32  instruction held in IF/ID.
REQ-015 PC_IF_ID_out  out  32  PC+4 of the IF/ID instruction.
REQ-016 Valid_IF_ID_out  out  1  IF/ID holds a real instruction, not a bubble.
REQ-017 Flush_ID_EX  out  1  combinational, equals Branch_EX; ID/EX must load a bubble.
REQ-018 Stall_count  out  16  saturating count of cycles with stall applied.
REQ-019 Flush_count  out  16  saturating count of IF/ID flushes.

Function
REQ-020 Each cycle, exactly one action SHALL be taken, with priority in this order: branch, stall, jump, fetch-miss, normal.
REQ-021 On branch (Branch_EX=1), the block SHALL load PC<=Branch_target_EX and load a bubble into IF/ID, regardless of IF_ID_stall.
REQ-022 On stall (IF_ID_stall=1, Branch_EX=0), the block SHALL hold PC, IR, PC field, and valid unchanged.
REQ-023 On jump (Jump_ID=1, no branch, no stall), the block SHALL load PC<=Jump_target_ID and load a bubble into IF/ID.
REQ-024 On fetch-miss (Instr_valid=0, no higher-priority event), the block SHALL hold PC and load a bubble into IF/ID.
REQ-025 In the normal case, the block SHALL load PC<=PC+4, IR<=Instr_data, PC field<=PC+4, and valid<=1.
REQ-026 A bubble SHALL consist of IR=NOP_INSTR, PC field=32'h0, and valid=0.
REQ-027 PC arithmetic SHALL be modulo 2^32, so PC 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-028 Redirect targets SHALL have bits [1:0] forced to 00 before loading into PC; PC[1:0] is always 00.
REQ-029 Latency SHALL be one cycle: an instruction at Instr_addr in cycle N appears on IR_IF_ID_out in cycle N+1.
REQ-030 Stall_count SHALL increment in every cycle where the stall action is taken, saturating at 16'hFFFF.
REQ-031 Flush_count SHALL increment in every cycle where the branch or jump action is taken, saturating at 16'hFFFF; fetch-miss bubbles are not counted.
REQ-032 Flush_ID_EX SHALL have no registered delay.

Reset
REQ-033 While reset=1, outputs SHALL be: PC=RESET_PC, IR=NOP_INSTR, PC field=0, valid=0, and both counters=0.
REQ-034 Reset asserted mid-stall or mid-redirect SHALL override immediately; the first fetch after deassertion is at RESET_PC.
REQ-035 Flush_ID_EX SHALL follow Branch_EX even during reset.

Structure
REQ-036 RESET_PC default, NOP_INSTR, and the 16-bit counter width SHALL reside in the shared pipeline constants package.
REQ-037 The IF/ID register (IR, PC field, valid, with hold and bubble controls) SHALL be one sub-module named if_id_reg; PC, next-PC selection, and counters stay in if_stage.

Verification
REQ-038 Scenario: reset released, Instr_valid=1, Instr_data=32'h8C08_0004 -> Instr_addr 0,4,8; IR_IF_ID_out=32'h8C08_0004 one cycle later; valid=1.
REQ-039 Scenario: IF_ID_stall=1 for 2 cycles with PC=32'h10 -> PC stays 32'h10; IR/PC field/valid unchanged; Stall_count +2.
REQ-040 Scenario: Branch_EX=1, Branch_target_EX=32'h0000_0103, IF_ID_stall=1 in the same cycle -> PC=32'h100; IF/ID bubble; Flush_ID_EX=1; Flush_count +1; Stall_count unchanged.
REQ-041 Scenario: Jump_ID=1, Jump_target_ID=32'h40 -> PC=32'h40 next cycle; IR=NOP_INSTR; valid=0; then fetch resumes at 32'h44.
REQ-042 Scenario: Instr_valid=0 for 3 cycles at PC=32'h20 -> PC held at 32'h20; three bubbles; no counter change.
REQ-043 Scenario: PC=32'hFFFF_FFFC normal fetch -> PC=0, PC_IF_ID_out=0; Stall_count preset by 65540 stall cycles reads 16'hFFFF; reset mid-stall -> all reset values.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared pipeline constants and helpers for the instruction-fetch stage.
package if_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;  // sll $0,$0,0
    localparam int unsigned CNT_W             = 16;

    // One action per cycle; declaration order mirrors the priority order.
    typedef enum logic [2:0] {
        ACT_BRANCH,
        ACT_STALL,
        ACT_JUMP,
        ACT_MISS,
        ACT_NORMAL
    } if_action_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Saturating increment for the performance counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == '1) ? cnt : cnt + CNT_W'(1);
    endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: instruction word, PC+4 field and valid flag,
// with hold (stall) and bubble (flush / fetch-miss) controls.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        bubble,
    input  logic [31:0] ir_in,
    input  logic [31:0] pc_in,
    output logic [31:0] ir,
    output logic [31:0] pc_field,
    output logic        valid
);

    // Bubble wins over hold so a redirect can flush a stalled register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir       <= NOP_INSTR;
            pc_field <= '0;
            valid    <= 1'b0;
        end else if (bubble) begin
            ir       <= NOP_INSTR;
            pc_field <= '0;
            valid    <= 1'b0;
        end else if (!hold) begin
            ir       <= ir_in;
            pc_field <= pc_in;
            valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID register
// instance, and saturating stall/flush counters.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             IF_ID_stall,
    input  logic             Branch_EX,
    input  logic [31:0]      Branch_target_EX,
    input  logic             Jump_ID,
    input  logic [31:0]      Jump_target_ID,
    input  logic             Instr_valid,
    input  logic [31:0]      Instr_data,
    output logic [31:0]      Instr_addr,
    output logic [31:0]      IR_IF_ID_out,
    output logic [31:0]      PC_IF_ID_out,
    output logic             Valid_IF_ID_out,
    output logic             Flush_ID_EX,
    output logic [CNT_W-1:0] Stall_count,
    output logic [CNT_W-1:0] Flush_count
);

    logic [31:0]      pc;
    logic [31:0]      pc_plus4;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    if_action_t       action;

    assign pc_plus4 = pc + 32'd4;

    // Pick exactly one action per cycle in priority order.
    always_comb begin
        action = ACT_NORMAL;
        if (Branch_EX)        action = ACT_BRANCH;
        else if (IF_ID_stall) action = ACT_STALL;
        else if (Jump_ID)     action = ACT_JUMP;
        else if (!Instr_valid) action = ACT_MISS;
    end

    // PC register: redirect, hold, or sequential advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            case (action)
                ACT_BRANCH: pc <= align_word(Branch_target_EX);
                ACT_JUMP:   pc <= align_word(Jump_target_ID);
                ACT_NORMAL: pc <= pc_plus4;
                default:    pc <= pc;
            endcase
        end
    end

    // Saturating event counters; fetch-miss bubbles are not flushes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (action == ACT_STALL)
                stall_cnt <= sat_inc(stall_cnt);
            if (action == ACT_BRANCH || action == ACT_JUMP)
                flush_cnt <= sat_inc(flush_cnt);
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (reset),
        .hold     (action == ACT_STALL),
        .bubble   (action == ACT_BRANCH || action == ACT_JUMP || action == ACT_MISS),
        .ir_in    (Instr_data),
        .pc_in    (pc_plus4),
        .ir       (IR_IF_ID_out),
        .pc_field (PC_IF_ID_out),
        .valid    (Valid_IF_ID_out)
    );

    assign Instr_addr  = pc;
    assign Flush_ID_EX = Branch_EX;
    assign Stall_count = stall_cnt;
    assign Flush_count = flush_cnt;

endmodule
